// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - free-running VGA timing source with counts, data-enable and start strobes
// Optional porch-timed vga_hsync_o/vga_vsync_o pulses are built when VGA_SYNC_PORCH_EN is defined.
module vga_sync_gen #(
    parameter int   TOTAL_COLS    = 800,
    parameter int   TOTAL_ROWS    = 525,
    parameter int   ACTIVE_COLS   = 640,
    parameter int   ACTIVE_ROWS   = 480,
    parameter int   H_FRONT_PORCH = 16,
    parameter int   H_SYNC_WIDTH  = 96,
    parameter int   V_FRONT_PORCH = 10,
    parameter int   V_SYNC_WIDTH  = 2,
    parameter logic SYNC_POL      = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    output logic       Hsync_o,
    output logic       Vsync_o,
    output logic       de_o,
    output logic [9:0] col_count_o,
    output logic [9:0] row_count_o,
    output logic       line_start_o,
    output logic       frame_start_o
`ifdef VGA_SYNC_PORCH_EN
    ,
    output logic       vga_hsync_o,
    output logic       vga_vsync_o
`endif
);

    localparam logic [9:0] C_LAST   = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] R_LAST   = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] C_ACTIVE = 10'(ACTIVE_COLS);
    localparam logic [9:0] R_ACTIVE = 10'(ACTIVE_ROWS);

    // Elaboration-time guards on the geometry; porch geometry is checked in every build.
    generate
        if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_total
            $error("vga_sync_gen: TOTAL_* must not exceed 1024");
        end
        if (ACTIVE_COLS >= TOTAL_COLS || ACTIVE_ROWS >= TOTAL_ROWS) begin : g_bad_active
            $error("vga_sync_gen: ACTIVE_* must be below TOTAL_*");
        end
        if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH > TOTAL_COLS ||
            ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH > TOTAL_ROWS) begin : g_bad_porch
            $error("vga_sync_gen: porch window exceeds line or frame");
        end
        if (H_SYNC_WIDTH < 1 || V_SYNC_WIDTH < 1 || $bits(SYNC_POL) != 1) begin : g_bad_width
            $error("vga_sync_gen: sync widths must be at least 1");
        end
    endgenerate

    logic       r_run;
    logic [9:0] r_col;
    logic [9:0] r_row;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_de;
    logic       r_line_start;
    logic       r_frame_start;

    logic [9:0] w_col_nxt;
    logic [9:0] w_row_nxt;
    logic       w_col_wrap;
    logic       w_h_act;
    logic       w_v_act;

    // Outputs are decoded from the next-state counts so they line up with the counts they accompany.
    always_comb begin
        w_col_wrap = (r_col == C_LAST);
        w_col_nxt  = 10'd0;
        w_row_nxt  = 10'd0;
        if (r_run) begin
            w_col_nxt = w_col_wrap ? 10'd0 : r_col + 10'd1;
            if (w_col_wrap) begin
                w_row_nxt = (r_row == R_LAST) ? 10'd0 : r_row + 10'd1;
            end else begin
                w_row_nxt = r_row;
            end
        end
    end

    assign w_h_act = (w_col_nxt < C_ACTIVE);
    assign w_v_act = (w_row_nxt < R_ACTIVE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_run         <= 1'b0;
            r_col         <= 10'd0;
            r_row         <= 10'd0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (!en_i) begin
            r_run         <= 1'b0;
            r_col         <= 10'd0;
            r_row         <= 10'd0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_col         <= w_col_nxt;
            r_row         <= w_row_nxt;
            r_hsync       <= w_h_act;
            r_vsync       <= w_v_act;
            r_de          <= w_h_act & w_v_act;
            r_line_start  <= (w_col_nxt == 10'd0);
            r_frame_start <= (w_col_nxt == 10'd0) && (w_row_nxt == 10'd0);
        end
    end

    assign Hsync_o       = r_hsync;
    assign Vsync_o       = r_vsync;
    assign de_o          = r_de;
    assign col_count_o   = r_col;
    assign row_count_o   = r_row;
    assign line_start_o  = r_line_start;
    assign frame_start_o = r_frame_start;

`ifdef VGA_SYNC_PORCH_EN
    localparam logic [9:0] H_PULSE_FIRST = 10'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [9:0] H_PULSE_LAST  = 10'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
    localparam logic [9:0] V_PULSE_FIRST = 10'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [9:0] V_PULSE_LAST  = 10'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

    logic r_vga_hsync;
    logic r_vga_vsync;
    logic w_h_pulse;
    logic w_v_pulse;

    assign w_h_pulse = (w_col_nxt >= H_PULSE_FIRST) && (w_col_nxt <= H_PULSE_LAST);
    assign w_v_pulse = (w_row_nxt >= V_PULSE_FIRST) && (w_row_nxt <= V_PULSE_LAST);

    // Idle level is the deasserted polarity, not zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_vga_hsync <= ~SYNC_POL;
            r_vga_vsync <= ~SYNC_POL;
        end else if (!en_i) begin
            r_vga_hsync <= ~SYNC_POL;
            r_vga_vsync <= ~SYNC_POL;
        end else begin
            r_vga_hsync <= w_h_pulse ? SYNC_POL : ~SYNC_POL;
            r_vga_vsync <= w_v_pulse ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign vga_hsync_o = r_vga_hsync;
    assign vga_vsync_o = r_vga_vsync;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen on a reduced geometry
module tb_vga_sync_gen;

    localparam int TC    = 100;
    localparam int TR    = 30;
    localparam int AC    = 80;
    localparam int AR    = 24;
    localparam int HFP   = 4;
    localparam int HSW   = 10;
    localparam int VFP   = 2;
    localparam int VSW   = 2;
    localparam int FRAME = TC * TR;
    localparam logic POL = 1'b0;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       en_i;
    logic       Hsync_o;
    logic       Vsync_o;
    logic       de_o;
    logic [9:0] col_count_o;
    logic [9:0] row_count_o;
    logic       line_start_o;
    logic       frame_start_o;
`ifdef VGA_SYNC_PORCH_EN
    logic       vga_hsync_o;
    logic       vga_vsync_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    vga_sync_gen #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW),
        .SYNC_POL(POL)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .en_i(en_i),
        .Hsync_o(Hsync_o),
        .Vsync_o(Vsync_o),
        .de_o(de_o),
        .col_count_o(col_count_o),
        .row_count_o(row_count_o),
        .line_start_o(line_start_o),
        .frame_start_o(frame_start_o)
`ifdef VGA_SYNC_PORCH_EN
        ,
        .vga_hsync_o(vga_hsync_o),
        .vga_vsync_o(vga_vsync_o)
`endif
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_to(input int c, input int r);
        int n = 0;
        while (!(col_count_o == 10'(c) && row_count_o == 10'(r)) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        checks++;
        if (!(col_count_o == 10'(c) && row_count_o == 10'(r))) begin
            errors++;
            $display("FAIL run_to: got col=%0d row=%0d required col=%0d row=%0d", col_count_o, row_count_o, c, r);
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        en_i    = 1'b1;
        repeat (3) tick();
        checks++;
        if ({Hsync_o, Vsync_o, de_o, line_start_o, frame_start_o} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000", {Hsync_o, Vsync_o, de_o, line_start_o, frame_start_o});
        end
        checks++;
        if (col_count_o !== 10'd0 || row_count_o !== 10'd0) begin
            errors++;
            $display("FAIL reset_counts: got %0d,%0d required 0,0", col_count_o, row_count_o);
        end
`ifdef VGA_SYNC_PORCH_EN
        checks++;
        if ({vga_hsync_o, vga_vsync_o} !== {~POL, ~POL}) begin
            errors++;
            $display("FAIL reset_porch: got %b required %b", {vga_hsync_o, vga_vsync_o}, {~POL, ~POL});
        end
`endif
        rst_n_i = 1'b1;
        tick();
        checks++;
        if (col_count_o !== 10'd0 || row_count_o !== 10'd0) begin
            errors++;
            $display("FAIL first_edge_counts: got %0d,%0d required 0,0", col_count_o, row_count_o);
        end
        checks++;
        if ({Hsync_o, Vsync_o, de_o, line_start_o, frame_start_o} !== 5'b11111) begin
            errors++;
            $display("FAIL first_edge_flags: got %b required 11111", {Hsync_o, Vsync_o, de_o, line_start_o, frame_start_o});
        end
    endtask

    task automatic test_h_active_edge();
        repeat (AC - 1) tick();
        checks++;
        if (col_count_o !== 10'(AC - 1) || {Hsync_o, de_o, line_start_o} !== 3'b110) begin
            errors++;
            $display("FAIL last_active_col: got col=%0d H/de/ls=%b required col=%0d 110", col_count_o, {Hsync_o, de_o, line_start_o}, AC - 1);
        end
        tick();
        checks++;
        if (col_count_o !== 10'(AC) || {Hsync_o, Vsync_o, de_o} !== 3'b010) begin
            errors++;
            $display("FAIL first_blank_col: got col=%0d H/V/de=%b required col=%0d 010", col_count_o, {Hsync_o, Vsync_o, de_o}, AC);
        end
    endtask

    task automatic test_v_active_edge();
        run_to(TC - 1, AR - 1);
        checks++;
        if (Vsync_o !== 1'b1 || Hsync_o !== 1'b0) begin
            errors++;
            $display("FAIL last_active_row_end: got V=%b H=%b required V=1 H=0", Vsync_o, Hsync_o);
        end
        tick();
        checks++;
        if (col_count_o !== 10'd0 || row_count_o !== 10'(AR)) begin
            errors++;
            $display("FAIL first_blank_row_counts: got %0d,%0d required 0,%0d", col_count_o, row_count_o, AR);
        end
        checks++;
        if ({line_start_o, Vsync_o, frame_start_o, Hsync_o, de_o} !== 5'b10010) begin
            errors++;
            $display("FAIL first_blank_row_flags: got ls/V/fs/H/de=%b required 10010", {line_start_o, Vsync_o, frame_start_o, Hsync_o, de_o});
        end
    endtask

    task automatic test_frame_wrap();
        int n;
        run_to(TC - 1, TR - 1);
        checks++;
        if (frame_start_o !== 1'b0 || Vsync_o !== 1'b0) begin
            errors++;
            $display("FAIL pre_wrap: got fs=%b V=%b required fs=0 V=0", frame_start_o, Vsync_o);
        end
        tick();
        checks++;
        if (col_count_o !== 10'd0 || row_count_o !== 10'd0 ||
            {frame_start_o, line_start_o, Vsync_o, Hsync_o, de_o} !== 5'b11111) begin
            errors++;
            $display("FAIL frame_wrap: got %0d,%0d fs/ls/V/H/de=%b required 0,0 11111", col_count_o, row_count_o,
                     {frame_start_o, line_start_o, Vsync_o, Hsync_o, de_o});
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start_o !== 1'b1 && n < 2 * FRAME);
        checks++;
        if (n != FRAME) begin
            errors++;
            $display("FAIL frame_period: got %0d required %0d", n, FRAME);
        end
        tick();
        checks++;
        if (frame_start_o !== 1'b0 || line_start_o !== 1'b0 || col_count_o !== 10'd1) begin
            errors++;
            $display("FAIL strobe_width: got fs=%b ls=%b col=%0d required 0 0 1", frame_start_o, line_start_o, col_count_o);
        end
    endtask

    task automatic test_enable_drop();
        run_to(30, 10);
        en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (col_count_o !== 10'd0 || row_count_o !== 10'd0 ||
                {Hsync_o, Vsync_o, de_o, line_start_o, frame_start_o} !== 5'b00000) begin
                errors++;
                $display("FAIL en_low_%0d: got %0d,%0d flags=%b required 0,0 00000", i, col_count_o, row_count_o,
                         {Hsync_o, Vsync_o, de_o, line_start_o, frame_start_o});
            end
`ifdef VGA_SYNC_PORCH_EN
            checks++;
            if ({vga_hsync_o, vga_vsync_o} !== {~POL, ~POL}) begin
                errors++;
                $display("FAIL en_low_porch_%0d: got %b required %b", i, {vga_hsync_o, vga_vsync_o}, {~POL, ~POL});
            end
`endif
        end
        en_i = 1'b1;
        tick();
        checks++;
        if (col_count_o !== 10'd0 || row_count_o !== 10'd0 ||
            {Hsync_o, Vsync_o, de_o, line_start_o, frame_start_o} !== 5'b11111) begin
            errors++;
            $display("FAIL restart: got %0d,%0d flags=%b required 0,0 11111", col_count_o, row_count_o,
                     {Hsync_o, Vsync_o, de_o, line_start_o, frame_start_o});
        end
        tick();
        checks++;
        if (col_count_o !== 10'd1 || row_count_o !== 10'd0 || frame_start_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_step: got %0d,%0d fs=%b required 1,0 0", col_count_o, row_count_o, frame_start_o);
        end
    endtask

    // Walks a whole frame against an independent position model.
    task automatic test_full_frame();
        int c;
        int r;
        logic [4:0] exp_flags;
        run_to(TC - 1, TR - 1);
        c = TC - 1;
        r = TR - 1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (c == TC - 1) begin
                c = 0;
                r = (r == TR - 1) ? 0 : r + 1;
            end else begin
                c = c + 1;
            end
            exp_flags = {c < AC, r < AR, (c < AC) && (r < AR), c == 0, (c == 0) && (r == 0)};
            checks++;
            if (col_count_o !== 10'(c) || row_count_o !== 10'(r) ||
                {Hsync_o, Vsync_o, de_o, line_start_o, frame_start_o} !== exp_flags) begin
                errors++;
                if (errors < 20)
                    $display("FAIL frame_walk: got %0d,%0d flags=%b required %0d,%0d %b", col_count_o, row_count_o,
                             {Hsync_o, Vsync_o, de_o, line_start_o, frame_start_o}, c, r, exp_flags);
            end
`ifdef VGA_SYNC_PORCH_EN
            checks++;
            if (vga_hsync_o !== (((c >= AC + HFP) && (c <= AC + HFP + HSW - 1)) ? POL : ~POL) ||
                vga_vsync_o !== (((r >= AR + VFP) && (r <= AR + VFP + VSW - 1)) ? POL : ~POL)) begin
                errors++;
                if (errors < 20)
                    $display("FAIL porch_walk: got h=%b v=%b at %0d,%0d", vga_hsync_o, vga_vsync_o, c, r);
            end
`endif
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        en_i    = 1'b1;
        test_reset();
        test_h_active_edge();
        test_v_active_edge();
        test_frame_wrap();
        test_enable_drop();
        test_full_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
